// File: rtl/asmi_readback_pkg.sv
// Shared definitions for the EPCS readback path: defaults, state encodings and
// the flash bit-order helper also used by the programming path.
package asmi_readback_pkg;

  localparam logic [23:0] START_ADDR_DEF     = 24'h100000;
  localparam int unsigned PAGE_BYTES_DEF     = 256;
  localparam int unsigned FIFO_SPACE_MIN_DEF = 256;
  localparam int unsigned ACK_TIMEOUT_DEF    = 25000000;
  localparam int unsigned TX_FIFO_DEPTH      = 2048;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    STREAM,
    NOTIFY,
    WAIT_ACK,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_STREAM
  } rd_state_t;

  // EPCS delivers bytes MSB-first relative to the image file.
  function automatic logic [7:0] bit_reverse8(input logic [7:0] b);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/asmi_page_reader.sv
// One-page ASMI burst: read strobe, rden window, bit-order restore and the
// one-cycle Tx write pipeline. start_page launches a burst; page_done marks the last write.
module asmi_page_reader
  import asmi_readback_pkg::*;
#(
  parameter int unsigned PAGE_BYTES = PAGE_BYTES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_page,
  input  logic [7:0] asmi_dataout,
  input  logic       asmi_data_valid,
  output logic       asmi_read,
  output logic       asmi_rden,
  output logic [7:0] tx_data,
  output logic       tx_wrreq,
  output logic       page_done
);

  localparam int unsigned CW = $clog2(PAGE_BYTES);

  rd_state_t     state, state_next;
  logic [CW-1:0] byte_count;
  logic          take;
  logic          last;

  assign take = (state == RD_STREAM) && asmi_data_valid;
  assign last = take && (byte_count == CW'(PAGE_BYTES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RD_IDLE;
    else       state <= state_next;
  end

  // Leaving STREAM on the last accepted byte drops rden in the same cycle
  // the final registered tx_wrreq is presented.
  always_comb begin
    state_next = state;
    asmi_read  = 1'b0;
    asmi_rden  = 1'b0;
    case (state)
      RD_IDLE:   if (start_page) state_next = RD_ISSUE;
      RD_ISSUE: begin
        asmi_read  = 1'b1;
        asmi_rden  = 1'b1;
        state_next = RD_STREAM;
      end
      RD_STREAM: begin
        asmi_rden = 1'b1;
        if (last) state_next = RD_IDLE;
      end
      default:   state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_count <= '0;
      tx_data    <= '0;
      tx_wrreq   <= 1'b0;
      page_done  <= 1'b0;
    end else begin
      tx_wrreq  <= take;
      page_done <= last;
      if (take) begin
        tx_data    <= bit_reverse8(asmi_dataout);
        byte_count <= byte_count + 1'b1;
      end
      if (start_page) byte_count <= '0;
    end
  end

endmodule

// File: rtl/asmi_readback.sv
// EPCS user-image readback: page sequencing, Tx FIFO space check, page_ready
// handshake with ACK timeout, and the running 16-bit checksum of restored bytes.
module asmi_readback
  import asmi_readback_pkg::*;
#(
  parameter logic [23:0] START_ADDR     = START_ADDR_DEF,
  parameter int unsigned PAGE_BYTES     = PAGE_BYTES_DEF,
  parameter int unsigned FIFO_SPACE_MIN = FIFO_SPACE_MIN_DEF,
  parameter int unsigned ACK_TIMEOUT    = ACK_TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] num_blocks,
  output logic        start_ACK,
  output logic [23:0] asmi_addr,
  output logic        asmi_read,
  output logic        asmi_rden,
  input  logic [7:0]  asmi_dataout,
  input  logic        asmi_data_valid,
  input  logic        asmi_busy,
  input  logic [10:0] tx_used,
  output logic [7:0]  tx_data,
  output logic        tx_wrreq,
  output logic        page_ready,
  input  logic        page_ready_ACK,
  output logic [15:0] checksum,
  output logic        done,
  output logic        timeout_err
);

  state_t      state, state_next;
  logic [13:0] blocks;
  logic [13:0] page;
  logic [23:0] addr;
  logic [31:0] tmo_cnt;
  logic [11:0] fifo_free;
  logic        space_ok;
  logic        tmo_hit;
  logic        accept;
  logic        start_page;
  logic        page_done;

  assign fifo_free = 12'(TX_FIFO_DEPTH) - {1'b0, tx_used};
  assign space_ok  = fifo_free >= 12'(FIFO_SPACE_MIN);
  assign tmo_hit   = tmo_cnt == 32'(ACK_TIMEOUT - 1);
  assign accept    = (state == IDLE) && start && !asmi_busy;

  assign start_ACK  = accept && !reset;
  assign asmi_addr  = addr;
  assign page_ready = (state == WAIT_ACK);
  assign done       = (state == FINISH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_page = 1'b0;
    case (state)
      IDLE:     if (accept) state_next = (num_blocks == '0) ? FINISH : CHECK;
      CHECK: begin
        if (page == blocks) begin
          state_next = FINISH;
        end else if (space_ok && !asmi_busy) begin
          start_page = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:    state_next = STREAM;
      STREAM:   if (page_done) state_next = NOTIFY;
      NOTIFY:   state_next = WAIT_ACK;
      WAIT_ACK: begin
        // ACK takes priority over a coincident timeout expiry.
        if (page_ready_ACK)   state_next = CHECK;
        else if (tmo_hit)     state_next = IDLE;
      end
      FINISH:   if (!start) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blocks      <= '0;
      page        <= '0;
      addr        <= START_ADDR;
      tmo_cnt     <= '0;
      checksum    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          addr <= START_ADDR;
          page <= '0;
          if (accept) begin
            blocks      <= num_blocks;
            timeout_err <= 1'b0;
          end
        end
        NOTIFY: begin
          page    <= page + 1'b1;
          addr    <= addr + 24'(PAGE_BYTES);
          tmo_cnt <= '0;
        end
        WAIT_ACK: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (!page_ready_ACK && tmo_hit) timeout_err <= 1'b1;
        end
        default: ;
      endcase

      if (accept)        checksum <= '0;
      else if (tx_wrreq) checksum <= checksum + {8'h00, tx_data};
    end
  end

  asmi_page_reader #(
    .PAGE_BYTES(PAGE_BYTES)
  ) u_reader (
    .clock           (clock),
    .reset           (reset),
    .start_page      (start_page),
    .asmi_dataout    (asmi_dataout),
    .asmi_data_valid (asmi_data_valid),
    .asmi_read       (asmi_read),
    .asmi_rden       (asmi_rden),
    .tx_data         (tx_data),
    .tx_wrreq        (tx_wrreq),
    .page_done       (page_done)
  );

endmodule

// File: tb/tb_asmi_readback.sv
// Scoreboard bench for asmi_readback: flash model with random gaps, ACK responder,
// expected addresses/bytes queued at stimulus time and checked by a monitor.
module tb_asmi_readback;

  localparam int unsigned ACK_TO   = 100;
  localparam logic [23:0] START_A  = 24'h100000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] num_blocks = '0;
  logic        start_ACK;
  logic [23:0] asmi_addr;
  logic        asmi_read;
  logic        asmi_rden;
  logic [7:0]  asmi_dataout = '0;
  logic        asmi_data_valid = 1'b0;
  logic        asmi_busy = 1'b0;
  logic [10:0] tx_used = '0;
  logic [7:0]  tx_data;
  logic        tx_wrreq;
  logic        page_ready;
  logic        page_ready_ACK = 1'b0;
  logic [15:0] checksum;
  logic        done;
  logic        timeout_err;

  asmi_readback #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clock(clock), .reset(reset), .start(start), .num_blocks(num_blocks),
    .start_ACK(start_ACK), .asmi_addr(asmi_addr), .asmi_read(asmi_read),
    .asmi_rden(asmi_rden), .asmi_dataout(asmi_dataout),
    .asmi_data_valid(asmi_data_valid), .asmi_busy(asmi_busy), .tx_used(tx_used),
    .tx_data(tx_data), .tx_wrreq(tx_wrreq), .page_ready(page_ready),
    .page_ready_ACK(page_ready_ACK), .checksum(checksum), .done(done),
    .timeout_err(timeout_err)
  );

  initial forever #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  logic [23:0] exp_addr_q[$];
  logic [7:0]  exp_byte_q[$];
  logic [15:0] exp_sum;
  logic [7:0]  seed = '0;
  int          wr_cnt = 0;
  int          read_cnt = 0;
  int          start_ack_cnt = 0;
  int          pr_hi_cnt = 0;
  logic        pr_d = 1'b0;
  bit          ack_en = 1'b1;
  int          ack_delay = 10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Image content as the PC would see it (restored bit order).
  function automatic logic [7:0] pat(input logic [23:0] a);
    return 8'(a[7:0] + a[15:8] * 8'd37 + seed);
  endfunction

  function automatic logic [7:0] flash_order(input logic [7:0] b);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) if (b[i]) r = r | (8'h80 >> i);
    return r;
  endfunction

  task automatic push_run(input int n);
    logic [23:0] a;
    exp_sum = '0;
    wr_cnt  = 0;
    for (int p = 0; p < n; p++) begin
      a = START_A + 24'(p * 256);
      exp_addr_q.push_back(a);
      for (int b = 0; b < 256; b++) begin
        exp_byte_q.push_back(pat(a + 24'(b)));
        exp_sum = exp_sum + 16'(pat(a + 24'(b)));
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor / scoreboard
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (tx_wrreq) begin
        wr_cnt++;
        if (exp_byte_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL tx_extra: unexpected write 0x%0h, expected none", tx_data);
        end else check("tx_data", 32'(tx_data), 32'(exp_byte_q.pop_front()));
      end
      if (asmi_read) begin
        read_cnt++;
        if (exp_addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL read_extra: unexpected read at 0x%0h, expected none", asmi_addr);
        end else check("asmi_addr", 32'(asmi_addr), 32'(exp_addr_q.pop_front()));
      end
      if (start_ACK) start_ack_cnt++;
      if (page_ready && !pr_d) begin
        pr_hi_cnt = 0;
        check("page_ready_after_full_page", 32'(wr_cnt % 256), 32'd0);
      end
      if (page_ready) pr_hi_cnt++;
    end
    pr_d = page_ready;
  end

  // Flash model: bytes in flash bit order, random gaps, occasional stray valid after rden drops
  initial begin
    logic [23:0] fl_addr = '0;
    int          fl_cnt = 0;
    bit          fl_active = 1'b0;
    bit          stray = 1'b0;
    forever begin
      @(negedge clock);
      asmi_data_valid = 1'b0;
      if (reset) begin
        fl_active = 1'b0;
        stray     = 1'b0;
      end else if (asmi_read) begin
        fl_addr   = asmi_addr;
        fl_cnt    = 0;
        fl_active = 1'b1;
      end else if (fl_active && asmi_rden) begin
        if ($urandom_range(3) != 0) begin
          asmi_dataout    = flash_order(pat(fl_addr + 24'(fl_cnt)));
          asmi_data_valid = 1'b1;
          fl_cnt++;
          if (fl_cnt == 256) begin
            fl_active = 1'b0;
            stray     = ($urandom_range(1) == 1);
          end
        end
      end else if (stray) begin
        asmi_dataout    = 8'($urandom);
        asmi_data_valid = 1'b1;
        stray           = 1'b0;
      end
    end
  end

  // Tx-side ACK responder
  initial begin
    int w = 0;
    forever begin
      @(negedge clock);
      page_ready_ACK = 1'b0;
      if (!reset && page_ready && ack_en) begin
        if (w == 0) begin
          page_ready_ACK = 1'b1;
          w = ack_delay;
        end else w--;
      end else w = ack_delay;
    end
  end

  task automatic run_pages(input int n, input bit full_fifo);
    int acks0, reads0, g;
    acks0  = start_ack_cnt;
    reads0 = read_cnt;
    push_run(n);
    num_blocks = 14'(n);
    start      = 1'b1;
    if (full_fifo) begin
      tick(40);
      check("no_read_fifo_1900", 32'(read_cnt - reads0), 32'd0);
      tx_used = 11'd1793;
      tick(20);
      check("no_read_fifo_1793", 32'(read_cnt - reads0), 32'd0);
      tx_used = 11'd1792;
    end
    g = 0;
    while (!done && g < 20000) begin
      tick(1);
      g++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("start_ack_once", 32'(start_ack_cnt - acks0), 32'd1);
    check("read_count", 32'(read_cnt - reads0), 32'(n));
    check("fifo_writes", 32'(wr_cnt), 32'(256 * n));
    check("checksum", 32'(checksum), 32'(exp_sum));
    check("queues_drained", 32'(exp_byte_q.size() + exp_addr_q.size()), 32'd0);
    start = 1'b0;
    tick(2);
    check("done_clears", 32'(done), 32'd0);
  endtask

  initial begin
    int g, a0;
    #1;
    tick(3);
    check("rst_start_ACK", 32'(start_ACK), 32'd0);
    check("rst_asmi_read", 32'(asmi_read), 32'd0);
    check("rst_asmi_rden", 32'(asmi_rden), 32'd0);
    check("rst_tx_wrreq", 32'(tx_wrreq), 32'd0);
    check("rst_page_ready", 32'(page_ready), 32'd0);
    check("rst_done_err", 32'({done, timeout_err}), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    check("rst_asmi_addr", 32'(asmi_addr), 32'h100000);
    reset = 1'b0;
    tick(2);

    // Single page, identity pattern
    seed = 8'd0;
    run_pages(1, 1'b0);
    check("single_page_checksum", 32'(checksum), 32'h7F80);

    // Three pages, fixed ACK latency
    seed = 8'd5; ack_delay = 10;
    run_pages(3, 1'b0);

    // FIFO back-pressure
    seed = 8'd9; tx_used = 11'd1900;
    run_pages(1, 1'b1);
    tx_used = '0;

    // ACK timeout
    seed = 8'd3; ack_en = 1'b0;
    push_run(1);
    a0 = start_ack_cnt;
    num_blocks = 14'd1; start = 1'b1;
    g = 0;
    while (start_ack_cnt == a0 && g < 20) begin tick(1); g++; end
    start = 1'b0;
    g = 0;
    while (!timeout_err && g < 3000) begin tick(1); g++; end
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    check("timeout_cycles", 32'(pr_hi_cnt), 32'(ACK_TO));
    check("timeout_page_ready", 32'(page_ready), 32'd0);
    check("timeout_checksum", 32'(checksum), 32'(exp_sum));
    ack_en = 1'b1;
    seed = 8'd77;
    run_pages(1, 1'b0);
    check("timeout_err_cleared", 32'(timeout_err), 32'd0);

    // Reset mid-burst
    seed = 8'd21;
    push_run(2);
    num_blocks = 14'd2; start = 1'b1;
    g = 0;
    while (wr_cnt < 40 && g < 5000) begin tick(1); g++; end
    check("reached_40_bytes", 32'(wr_cnt >= 40), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_rden", 32'(asmi_rden), 32'd0);
    check("rst_mid_wrreq", 32'(tx_wrreq), 32'd0);
    check("rst_mid_page_ready", 32'(page_ready), 32'd0);
    exp_byte_q.delete();
    exp_addr_q.delete();
    start = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_mid_checksum", 32'(checksum), 32'd0);
    check("rst_mid_addr", 32'(asmi_addr), 32'h100000);
    seed = 8'd44;
    run_pages(1, 1'b0);

    // Zero blocks
    run_pages(0, 1'b0);

    // Start refused while ASMI busy
    a0 = start_ack_cnt;
    asmi_busy = 1'b1; num_blocks = 14'd1; start = 1'b1;
    tick(5);
    check("busy_blocks_start", 32'(start_ack_cnt - a0), 32'd0);
    start = 1'b0; asmi_busy = 1'b0;
    tick(2);

    // Randomized runs
    for (int r = 0; r < 3; r++) begin
      seed      = 8'($urandom);
      tx_used   = 11'($urandom_range(0, 1792));
      ack_delay = $urandom_range(0, 30);
      run_pages($urandom_range(1, 3), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/asmi_readback.md
Name: asmi_readback

Overview:
- Reads back the user image region of the EPCS configuration flash, one 256-byte page at a time.
- Streams each page to the Tx path for PC-side verification after programming.
- Keeps a 16-bit running checksum with the same arithmetic the programming path uses, so the PC can compare the two directly.
- Sits between the ASMI megafunction read port and the Tx byte FIFO, driven by the Rx command decoder.

Parameters:
- START_ADDR, 24'h100000, first flash byte address read (top 1MB image region).
- PAGE_BYTES, 256, bytes per page and per Tx block.
- FIFO_SPACE_MIN, 256, minimum free Tx FIFO words before a page read starts.
- ACK_TIMEOUT, 25000000, clocks to wait for page_ready_ACK before aborting.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; readback requested by Rx decoder.
- num_blocks  in  14  number of pages to read; sampled on start.
- start_ACK  out  1  high for the one cycle the request is accepted.
- asmi_addr  out  24  flash byte address to ASMI.
- asmi_read  out  1  one-cycle read strobe; loads asmi_addr.
- asmi_rden  out  1  held high for the duration of a page burst.
- asmi_dataout  in  8  byte from ASMI, flash bit order.
- asmi_data_valid  in  1  asmi_dataout valid this cycle.
- asmi_busy  in  1  ASMI busy.
- tx_used  in  11  Tx FIFO fill level.
- tx_data  out  8  byte to Tx FIFO, bit order restored (bit i = asmi_dataout[7-i]).
- tx_wrreq  out  1  Tx FIFO write strobe.
- page_ready  out  1  page in FIFO; held until acknowledged.
- page_ready_ACK  in  1  Tx has framed the page.
- checksum  out  16  running sum of restored bytes, modulo 2^16.
- done  out  1  all pages sent; held until start is low.
- timeout_err  out  1  set on ACK timeout; cleared by the next accepted start.

Behaviour:
- Reset values: all outputs 0; state IDLE; asmi_addr = START_ADDR.

State machine:
- IDLE
  - Holds addr = START_ADDR, page = 0, byte_count = 0.
  - On start and !asmi_busy: latch num_blocks, clear checksum and timeout_err, pulse start_ACK, go to CHECK.
  - If latched num_blocks == 0, go directly to FINISH.
- CHECK
  - If page == blocks: go to FINISH.
  - Else wait for (2048 - tx_used) >= FIFO_SPACE_MIN and !asmi_busy, then go to ISSUE.
- ISSUE
  - Drive asmi_read = 1 and asmi_rden = 1 for one cycle, then go to STREAM.
- STREAM
  - asmi_rden stays 1.
  - On each asmi_data_valid:
    - tx_data <= reversed byte, tx_wrreq <= 1 on the next cycle (1-cycle latency).
    - checksum += zero-extended restored byte.
    - byte_count++.
  - When byte_count reaches PAGE_BYTES: drop asmi_rden in the same cycle as the last tx_wrreq, then go to NOTIFY.
  - asmi_data_valid arriving after rden has dropped is ignored.
- NOTIFY
  - page_ready <= 1; page++; addr += PAGE_BYTES; zero the timeout counter; go to WAIT_ACK.
- WAIT_ACK
  - On page_ready_ACK: clear page_ready, go to CHECK.
  - Timeout counter increments each cycle. At ACK_TIMEOUT: set timeout_err, clear page_ready, go to IDLE.
- FINISH
  - done <= 1; hold until start is low, then go to IDLE.

Arithmetic and boundary rules:
- asmi_addr advances by PAGE_BYTES per page and wraps modulo 2^24. No range check; the PC bounds num_blocks.
- start while not IDLE is ignored; start_ACK never pulses outside IDLE.
- page_ready_ACK outside WAIT_ACK is ignored.
- tx_used is sampled only in CHECK. The per-page space guarantee means tx_wrreq never needs back-pressure mid-page.
- Reset mid-burst aborts immediately: asmi_rden drops asynchronously and any partial page is discarded.
- Simultaneous page_ready_ACK and timeout expiry: the ACK wins.

Decomposition:
- Shared package holds:
  - START_ADDR default and PAGE_BYTES;
  - the state encoding;
  - a bit_reverse8 function, also used by the programming path.
- One natural sub-module: asmi_page_reader. It owns ISSUE/STREAM, byte_count, bit reversal and the tx_wrreq pipeline, with a start_page/page_done handshake.
- The top level keeps page sequencing, the ACK handshake, timeout and checksum.

Test Plan:
1. Single page:
   - Stimulus: num_blocks = 1; flash model holds bytes 0x00..0xFF at 0x100000 in flash bit order.
   - Required: 256 tx_wrreq; tx_data 0x00..0xFF in order; checksum = 0x7F80; page_ready then done; asmi_read pulsed once with addr 0x100000.
2. Multi-page:
   - Stimulus: num_blocks = 3, each page ACKed after 10 cycles.
   - Required: asmi_read addresses 0x100000, 0x100100, 0x100200; 768 FIFO writes; done = 1.
3. FIFO back-pressure:
   - Stimulus: tx_used = 1900 on entry to CHECK.
   - Required: no asmi_read until tx_used <= 1792; then the page proceeds normally.
4. ACK timeout:
   - Stimulus: ACK_TIMEOUT overridden to 100; page_ready_ACK never asserted.
   - Required: timeout_err = 1 at 100 cycles; page_ready = 0; return to IDLE; the next start clears timeout_err.
5. Reset mid-burst:
   - Stimulus: assert reset after 40 bytes of page 0.
   - Required: asmi_rden, tx_wrreq and page_ready all 0 immediately; after release, a new start re-reads from 0x100000 with checksum restarted at 0.
6. Edge handshakes:
   - Stimulus: num_blocks = 0 with start; separately, start held high during STREAM.
   - Required: num_blocks = 0 gives done with no asmi_read. start held during STREAM produces no second start_ACK until the FINISH→IDLE return.
